// File: rtl/decoder_pkg.sv
// Shared code/one-hot types and conversion helpers for the 2-to-4 decoder family.
// The encode helper is the inverse mapping used by encoder-side designs and benches.
package decoder_pkg;

    localparam int unsigned CODE_W   = 2;
    localparam int unsigned ONEHOT_W = 4;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    typedef enum logic [1:0] {
        OUT_HOLD  = 2'd0,
        OUT_LOAD  = 2'd1,
        OUT_DRAIN = 2'd2
    } out_action_e;

    function automatic onehot_t onehot_decode(input code_t code, input logic en);
        onehot_t result;
        result = '0;
        for (int unsigned i = 0; i < ONEHOT_W; i++) begin
            if (en && (code == code_t'(i))) begin
                result[i] = 1'b1;
            end
        end
        return result;
    endfunction

    function automatic code_t onehot_encode(input onehot_t onehot);
        code_t result;
        result = '0;
        for (int unsigned i = 0; i < ONEHOT_W; i++) begin
            if (onehot[i]) begin
                result = code_t'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/decoder2to4_stream_if.sv
// Stream bundle for decoder2to4_stream: code input handshake, decoded output handshake
// and FIFO status. The slave modport is the decoder side.
interface decoder2to4_stream_if
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    code_t            in_code;
    logic             in_ready;
    logic             en;
    onehot_t          dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (
        output in_valid,
        output in_code,
        output en,
        output dout_ready,
        input  in_ready,
        input  dout,
        input  dout_valid,
        input  count,
        input  full,
        input  empty
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  en,
        input  dout_ready,
        output in_ready,
        output dout,
        output dout_valid,
        output count,
        output full,
        output empty
    );

endinterface

// File: rtl/decoder2to4_stream_sync_fifo.sv
// Synchronous FIFO holding raw codes ahead of the decoder output stage.
// Pointers wrap modulo DEPTH (power of two); full/empty derive from the occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_w;
    logic             empty_w;
    logic             push_ok;
    logic             pop_ok;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    // Guard against misuse so occupancy can never over- or underflow.
    assign push_ok = push && !full_w;
    assign pop_ok  = pop && !empty_w;

    always_comb begin
        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_w;
    assign empty = empty_w;

endmodule

// File: rtl/decoder2to4_stream.sv
// Buffered 2-to-4 decoder: codes queue in sync_fifo and are decoded into a registered
// one-hot output stage with valid/ready handshake; en is sampled when an entry loads.
module decoder2to4_stream
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder2to4_stream_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             push;
    logic             load;
    code_t            head_code;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             in_ready_w;

    onehot_t          dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    out_action_e      action;

    // Space freed by a same-cycle load is not offered to the producer until next cycle.
    assign in_ready_w = !fifo_full && !rst;
    assign push       = bus.in_valid && in_ready_w;
    assign load       = !fifo_empty && (!dout_valid_q || bus.dout_ready);

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.in_code),
        .pop   (load),
        .rdata (head_code),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        action = OUT_HOLD;
        if (load) begin
            action = OUT_LOAD;
        end else if (dout_valid_q && bus.dout_ready) begin
            action = OUT_DRAIN;
        end
    end

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        unique case (action)
            OUT_LOAD: begin
                dout_d       = onehot_decode(head_code, bus.en);
                dout_valid_d = 1'b1;
            end
            OUT_DRAIN: begin
                dout_d       = '0;
                dout_valid_d = 1'b0;
            end
            default: begin
                dout_d       = dout_q;
                dout_valid_d = dout_valid_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.count      = fifo_count;
    assign bus.full       = fifo_full;
    assign bus.empty      = fifo_empty;

endmodule

// File: doc/decoder2to4_stream.md
DECODER2TO4_STREAM -- requirements
Module: decoder2to4_stream

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entries (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  producer offers a code.
REQ-005 in_code  input  2  binary code to decode.
REQ-006 in_ready  output  1  block can accept a code this cycle.
REQ-007 en  input  1  decoder enable; sampled when a FIFO entry moves to the output stage.
REQ-008 dout  output  4  registered one-hot decode result.
REQ-009 dout_valid  output  1  dout holds an undelivered result.
REQ-010 dout_ready  input  1  consumer accepts dout this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  current FIFO occupancy, output stage excluded.
REQ-012 full, empty  output  1 each  FIFO status flags.

Function
REQ-013 Push SHALL occur on an edge where in_valid && in_ready; in_code is written at the write pointer.
REQ-014 in_ready SHALL equal !full && !rst; a pop on the same cycle does not free space for a push when full.
REQ-015 Load SHALL occur on an edge where !empty && (!dout_valid || dout_ready); the head entry moves to the output register and the read pointer advances.
REQ-016 On load, dout SHALL be 4'b0001 << code when en=1, and 4'b0000 when en=0; dout_valid SHALL be set to 1 in both cases.
REQ-017 Handshake: dout and dout_valid SHALL hold stable while dout_valid && !dout_ready.
REQ-018 When dout_valid && dout_ready and the FIFO is empty, dout_valid SHALL clear next edge and dout SHALL return to 4'b0000.
REQ-019 Latency: a code pushed at edge k into an empty FIFO with a free output stage SHALL appear with dout_valid=1 after edge k+1; no same-cycle bypass.
REQ-020 Throughput: with dout_ready held 1 and continuous input, one result per cycle.
REQ-021 Simultaneous push and load on the same edge SHALL leave count unchanged; push only increments it; load only decrements it.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
REQ-023 Order SHALL be preserved: results leave in push order, with no loss or duplication.
REQ-024 en changes SHALL affect only entries loaded after the change; entries already in the output stage are unchanged.

Reset
REQ-025 While rst=1, the block SHALL force asynchronously: pointers=0, count=0, empty=1, full=0, dout=4'b0000, dout_valid=0, in_ready=0.
REQ-026 Reset asserted mid-operation SHALL discard all queued and output-stage codes; no stale result appears after release.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-028 Shared package decoder_pkg SHALL hold CODE_W=2, ONEHOT_W=4 and the one-hot decode function, reused by encoder/decoder benches.
REQ-029 Storage and pointers SHALL live in one sub-module, sync_fifo (parameters WIDTH, DEPTH); the decode and output stage stay in decoder2to4_stream.

Verification
REQ-030 Reset then push 0,1,2,3 with en=1, dout_ready=1 -> dout 0001,0010,0100,1000 on consecutive cycles, first result one cycle after first push.
REQ-031 Hold dout_ready=0 and push 5 codes with DEPTH=4 -> 1 code in the output stage, count=4, full=1, in_ready=0, dout stable; then release -> all 5 codes drain in order.
REQ-032 Push code 2 with en=0, then code 2 with en=1 -> dout 0000 (valid), then 0100.
REQ-033 Full FIFO, dout_ready=1, in_valid=1 -> no push on that edge; count goes 4->3, then refills on the next edge.
REQ-034 Assert rst for 1 cycle with 3 codes queued and dout_valid=1 -> immediate dout=0000, dout_valid=0, count=0; no old code appears afterwards.
REQ-035 Loopback: drive each result through encoder4to2 -> recovered code equals pushed code for all four codes (en=1).
